// File: rtl/bp_be_fp_rec_to_ieee_if.sv
// rtl/bp_be_fp_rec_to_ieee_if.sv - ready/valid bundle for the recoded-to-IEEE FP decoder
// slave: decoder side; master: producer/consumer side.
interface bp_be_fp_rec_to_ieee_if;
   localparam int dpath_width_gp = 66;

   logic [dpath_width_gp-1:0] reg_i;
   logic                      v_i;
   logic                      ready_and_o;
   logic [63:0]               ieee_o;
   logic                      sp_o;
   logic                      v_o;
   logic                      ready_and_i;

   modport slave (
      input  reg_i, v_i, ready_and_i,
      output ready_and_o, ieee_o, sp_o, v_o
   );

   modport master (
      output reg_i, v_i, ready_and_i,
      input  ready_and_o, ieee_o, sp_o, v_o
   );
endinterface

// File: rtl/bp_be_fp_rec_to_ieee.sv
// rtl/bp_be_fp_rec_to_ieee.sv - two-stage decoder from tagged dp-recoded FP value to IEEE bits
// BP_BE_FP_NAN_PAYLOAD_EN: when defined, NaN sign/payload pass through instead of canonical NaN.
module bp_be_fp_rec_to_ieee #(
   parameter int pipe_depth_p = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   bp_be_fp_rec_to_ieee_if.slave         io
);

   typedef enum logic [1:0] {
      e_cls_zero,
      e_cls_inf,
      e_cls_nan,
      e_cls_fin
   } cls_e;

   if (pipe_depth_p != 2) begin : g_bad_depth
      $error("bp_be_fp_rec_to_ieee: pipe_depth_p must be 2");
   end

   logic               s1_v;
   cls_e               s1_cls;
   logic               s1_sign;
   logic               s1_sp;
   logic signed [12:0] s1_e;
   logic [51:0]        s1_fract;
   logic [5:0]         s1_shamt;

   logic               s2_v;
   logic [63:0]        s2_ieee;
   logic               s2_sp;

   logic               s1_load;
   logic               s2_load;

   assign s2_load        = ~s2_v | (s2_v & io.ready_and_i);
   assign s1_load        = ~s1_v | s2_load;
   assign io.ready_and_o = ~s1_v | s2_load;
   assign io.v_o         = s2_v;
   assign io.ieee_o      = s2_ieee;
   assign io.sp_o        = s2_sp;

   logic [11:0]        in_exp;
   logic signed [12:0] in_e;
   logic signed [12:0] in_dist;
   logic [5:0]         in_shamt;
   cls_e               in_cls;

   // Subnormal shift is relative to the target format's minimum normal exponent.
   always_comb begin
      in_exp  = io.reg_i[63:52];
      in_e    = $signed({1'b0, in_exp}) - 13'sd2048;
      in_dist = io.reg_i[65] ? (-13'sd126 - in_e) : (-13'sd1022 - in_e);
      if (in_dist > 13'sd63) begin
         in_shamt = 6'd63;
      end else if (in_dist < 13'sd0) begin
         in_shamt = 6'd0;
      end else begin
         in_shamt = in_dist[5:0];
      end
      case (in_exp[11:9])
         3'b000:  in_cls = e_cls_zero;
         3'b110:  in_cls = e_cls_inf;
         3'b111:  in_cls = e_cls_nan;
         default: in_cls = e_cls_fin;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_v     <= 1'b0;
         s1_cls   <= e_cls_zero;
         s1_sign  <= 1'b0;
         s1_sp    <= 1'b0;
         s1_e     <= '0;
         s1_fract <= '0;
         s1_shamt <= '0;
      end else if (s1_load) begin
         s1_v <= io.v_i;
         if (io.v_i) begin
            s1_cls   <= in_cls;
            s1_sign  <= io.reg_i[64];
            s1_sp    <= io.reg_i[65];
            s1_e     <= in_e;
            s1_fract <= io.reg_i[51:0];
            s1_shamt <= in_shamt;
         end
      end
   end

   logic [52:0] dp_sub;
   logic [23:0] sp_sub;
   logic [12:0] dp_bexp;
   logic [12:0] sp_bexp;
   logic [63:0] nan_val;
   logic [63:0] pack;
   logic        unused_bits;

   assign unused_bits = ^{dp_sub[52], sp_sub[23], dp_bexp[12:11], sp_bexp[12:8]};

   always_comb begin
      dp_sub  = {1'b1, s1_fract} >> s1_shamt;
      sp_sub  = {1'b1, s1_fract[51:29]} >> s1_shamt;
      dp_bexp = s1_e + 13'sd1023;
      sp_bexp = s1_e + 13'sd127;
`ifdef BP_BE_FP_NAN_PAYLOAD_EN
      nan_val = s1_sp ? {32'hFFFF_FFFF, s1_sign, 8'hFF, s1_fract[51:29]}
                      : {s1_sign, 11'h7FF, s1_fract};
`else
      nan_val = s1_sp ? 64'hFFFF_FFFF_7FC0_0000 : 64'h7FF8_0000_0000_0000;
`endif
      pack = '0;
      case (s1_cls)
         e_cls_zero: pack = s1_sp ? {32'hFFFF_FFFF, s1_sign, 31'b0} : {s1_sign, 63'b0};
         e_cls_inf:  pack = s1_sp ? {32'hFFFF_FFFF, s1_sign, 8'hFF, 23'b0}
                                  : {s1_sign, 11'h7FF, 52'b0};
         e_cls_nan:  pack = nan_val;
         default: begin
            if (s1_sp) begin
               if (s1_e < -13'sd126) begin
                  pack = {32'hFFFF_FFFF, s1_sign, 8'b0, sp_sub[22:0]};
               end else begin
                  pack = {32'hFFFF_FFFF, s1_sign, sp_bexp[7:0], s1_fract[51:29]};
               end
            end else begin
               if (s1_e < -13'sd1022) begin
                  pack = {s1_sign, 11'b0, dp_sub[51:0]};
               end else begin
                  pack = {s1_sign, dp_bexp[10:0], s1_fract};
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s2_v    <= 1'b0;
         s2_ieee <= '0;
         s2_sp   <= 1'b0;
      end else if (s2_load) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_ieee <= pack;
            s2_sp   <= s1_sp;
         end
      end
   end

endmodule
